// File: rtl/mmio_pkg.sv
// mmio_pkg: shared types and constants for the memory-mapped UART transmitter.
//   tx_state_t          - transmitter FSM states
//   TX_ADDR_DEF         - default store address that enqueues a word
//   STATUS_ADDR_DEF     - default status read / overflow-clear address
//   ST_*                - bit positions inside the status word
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [15:0] TX_ADDR_DEF     = 16'hFF00;
    localparam logic [15:0] STATUS_ADDR_DEF = 16'hFF02;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with simultaneous push and pop.
//   clk, reset (async active-low)
//   push/din   - write request and data; ignored when full unless pop is also set
//   pop/dout   - read request (ignored when empty) and head-of-queue data
//   full/empty - occupancy flags
//   count      - number of stored entries, 0..DEPTH
module sync_fifo #(
    parameter int N     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [N-1:0]             din,
    output logic [N-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;
    logic          full_s;
    logic          empty_s;

    // Occupancy flags and accepted operations; a push into a full FIFO is
    // only accepted when the head leaves in the same cycle.
    always_comb begin
        full_s    = (count_r == CW'(DEPTH));
        empty_s   = (count_r == '0);
        pop_ok_s  = pop && !empty_s;
        push_ok_s = push && (!full_s || pop_ok_s);
    end

    // Storage, pointers (wrap modulo DEPTH) and entry count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped serial transmitter on the CPU store bus.
//   clk, reset (async active-low)
//   memwrite/dataadr/writedata - CPU store bus; stores to TX_ADDR enqueue a
//                                word, stores to STATUS_ADDR clear overflow
//   readdata - status word when dataadr == STATUS_ADDR, else 0 (combinational)
//   tx       - serial line (start 0, N data bits LSB first, stop 1), idles at 1
//   busy     - frame in progress or words still queued
//   overflow - sticky: a store was dropped because the FIFO was full
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter int           N            = 16,
    parameter logic [N-1:0] TX_ADDR      = TX_ADDR_DEF,
    parameter logic [N-1:0] STATUS_ADDR  = STATUS_ADDR_DEF,
    parameter int           CLKS_PER_BIT = 4,
    parameter int           DEPTH        = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memwrite,
    input  logic [N-1:0] dataadr,
    input  logic [N-1:0] writedata,
    output logic [N-1:0] readdata,
    output logic         tx,
    output logic         busy,
    output logic         overflow
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    tx_state_t     state_r;
    tx_state_t     state_next_s;
    logic [BW-1:0] baud_r;
    logic [BW-1:0] baud_next_s;
    logic [IW-1:0] idx_r;
    logic [IW-1:0] idx_next_s;
    logic [N-1:0]  shift_r;
    logic [N-1:0]  shift_next_s;
    logic          tx_r;
    logic          tx_next_s;
    logic          ovf_r;
    logic          ovf_next_s;

    logic          push_req_s;
    logic          clr_req_s;
    logic          drop_s;
    logic          pop_s;
    logic [N-1:0]  head_s;
    logic          full_s;
    logic          empty_s;
    logic [CW-1:0] count_s;
    logic [N-1:0]  status_s;

    sync_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req_s),
        .pop   (pop_s),
        .din   (writedata),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Store decode; a push is only lost when the FIFO is full and the FSM is
    // not draining the head in the same cycle.
    always_comb begin
        push_req_s = memwrite && (dataadr == TX_ADDR);
        clr_req_s  = memwrite && (dataadr == STATUS_ADDR);
        drop_s     = push_req_s && full_s && !pop_s;
        if (drop_s) begin
            ovf_next_s = 1'b1;
        end else if (clr_req_s) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, baud counter, bit index and shift register updates.
    // Each state holds for CLKS_PER_BIT cycles: the counter is loaded with
    // CLKS_PER_BIT-1 and the state advances on the cycle it reads zero.
    always_comb begin
        state_next_s = state_r;
        baud_next_s  = baud_r;
        idx_next_s   = idx_r;
        shift_next_s = shift_r;
        pop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s        = 1'b1;
                    shift_next_s = head_s;
                    baud_next_s  = BAUD_MAX;
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (baud_r == '0) begin
                    baud_next_s  = BAUD_MAX;
                    idx_next_s   = '0;
                    state_next_s = DATA;
                end else begin
                    baud_next_s = baud_r - 1'b1;
                end
            end
            DATA: begin
                if (baud_r == '0) begin
                    baud_next_s  = BAUD_MAX;
                    shift_next_s = shift_r >> 1;
                    if (idx_r == IDX_LAST) begin
                        state_next_s = STOP;
                    end else begin
                        idx_next_s = idx_r + 1'b1;
                    end
                end else begin
                    baud_next_s = baud_r - 1'b1;
                end
            end
            STOP: begin
                if (baud_r == '0) begin
                    // Back-to-back frames: go straight to the next start bit.
                    if (!empty_s) begin
                        pop_s        = 1'b1;
                        shift_next_s = head_s;
                        baud_next_s  = BAUD_MAX;
                        state_next_s = START;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    baud_next_s = baud_r - 1'b1;
                end
            end
            default: begin
                state_next_s = IDLE;
                baud_next_s  = '0;
                idx_next_s   = '0;
            end
        endcase
    end

    // Line level computed from the next state so tx is a clean flop output.
    always_comb begin
        case (state_next_s)
            START:   tx_next_s = 1'b0;
            DATA:    tx_next_s = shift_next_s[0];
            default: tx_next_s = 1'b1;
        endcase
    end

    // Datapath registers; reset returns the line to idle immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_r  <= '0;
            idx_r   <= '0;
            shift_r <= '0;
            tx_r    <= 1'b1;
            ovf_r   <= 1'b0;
        end else begin
            baud_r  <= baud_next_s;
            idx_r   <= idx_next_s;
            shift_r <= shift_next_s;
            tx_r    <= tx_next_s;
            ovf_r   <= ovf_next_s;
        end
    end

    // Status word assembly and read mux.
    always_comb begin
        status_s                       = '0;
        status_s[ST_BUSY]              = (state_r != IDLE) || !empty_s;
        status_s[ST_FULL]              = full_s;
        status_s[ST_EMPTY]             = empty_s;
        status_s[ST_OVF]               = ovf_r;
        status_s[ST_CNT_LSB +: CW]     = count_s;
        if (dataadr == STATUS_ADDR) begin
            readdata = status_s;
        end else begin
            readdata = '0;
        end
    end

    assign tx       = tx_r;
    assign busy     = (state_r != IDLE) || !empty_s;
    assign overflow = ovf_r;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed stimulus with a frame scoreboard. Stimulus pushes
// each word it expects on the line into sb; the monitor decodes every frame
// seen on tx, checks its bit-by-bit shape and compares the word to sb.
module tb_mmio_uart_tx;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [15:0] dataadr;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        tx;
    logic        busy;
    logic        overflow;

    int          tests;
    int          fails;
    int          frames_done;
    int          frames_aborted;
    logic [15:0] sb [$];

    mmio_uart_tx dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .readdata  (readdata),
        .tx        (tx),
        .busy      (busy),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Drive a store so it is sampled at the next rising edge.
    task automatic store(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        memwrite  = 1'b1;
        dataadr   = addr;
        writedata = data;
        @(posedge clk);
    endtask

    task automatic bus_idle();
        @(negedge clk);
        memwrite  = 1'b0;
        dataadr   = 16'h0000;
        writedata = 16'h0000;
    endtask

    task automatic read_status(output logic [15:0] v);
        dataadr = 16'hFF02;
        #1;
        v = readdata;
        dataadr = 16'h0000;
    endtask

    // Called at a negedge; counts edges until busy is low (bounded).
    task automatic wait_idle(inout int cyc, input int limit);
        while (busy === 1'b1 && cyc < limit) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    // Monitor: the first low sample of tx starts a frame of 18 bits x 4 cycles.
    initial begin : monitor
        logic [15:0] exp_w;
        logic [15:0] got_w;
        logic        eb;
        int          shape_err;
        bit          aborted;
        bit          have;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx === 1'b0) begin
                have      = (sb.size() > 0);
                exp_w     = have ? sb.pop_front() : 16'h0000;
                got_w     = 16'h0000;
                shape_err = 0;
                aborted   = 1'b0;
                for (int b = 0; b < 18; b++) begin
                    for (int c = 0; c < 4; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (reset !== 1'b1) aborted = 1'b1;
                        if (!aborted) begin
                            if (b == 0) eb = 1'b0;
                            else if (b == 17) eb = 1'b1;
                            else eb = exp_w[b-1];
                            if (tx !== eb) shape_err++;
                            if (c == 1 && b >= 1 && b <= 16) got_w[b-1] = tx;
                        end
                    end
                end
                if (!have) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected_frame: got word %0h, want no frame", got_w);
                end else if (aborted) begin
                    frames_aborted++;
                end else begin
                    check("frame_word", {16'h0, got_w}, {16'h0, exp_w});
                    check("frame_shape_errs", shape_err, 0);
                    frames_done++;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [15:0] st;
        int          cyc;
        int          bad;
        tests = 0; fails = 0; frames_done = 0; frames_aborted = 0;
        reset = 1'b0; memwrite = 1'b0; dataadr = 16'h0000; writedata = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_readdata", readdata, 16'h0000);
        check("rst_ovf", overflow, 0);
        reset = 1'b1;
        @(negedge clk);
        read_status(st);
        check("idle_status", st, 16'h0004);

        // Single frame 0x0096
        sb.push_back(16'h0096);
        store(16'hFF00, 16'h0096);
        bus_idle();
        check("t1_tx_before_pop", tx, 1);
        check("t1_busy_after_store", busy, 1);
        cyc = 0;
        @(posedge clk); cyc++; @(negedge clk);
        check("t1_tx_fall", tx, 0);
        wait_idle(cyc, 200);
        check("t1_busy_drop_cycles", cyc, 73);

        // Back-to-back frames
        sb.push_back(16'hA5A5);
        sb.push_back(16'h5A5A);
        store(16'hFF00, 16'hA5A5);
        store(16'hFF00, 16'h5A5A);
        bus_idle();
        cyc = 0;
        repeat (10) begin
            @(posedge clk); cyc++; @(negedge clk);
        end
        read_status(st);
        check("t2_status_during_frame1", st, 16'h0011);
        wait_idle(cyc, 400);
        check("t2_total_cycles", cyc, 144);

        // Overflow: six stores into an idle block
        sb.push_back(16'h1234);
        sb.push_back(16'h8001);
        sb.push_back(16'hFFFF);
        sb.push_back(16'h0000);
        sb.push_back(16'hC3C3);
        store(16'hFF00, 16'h1234);
        store(16'hFF00, 16'h8001);
        store(16'hFF00, 16'hFFFF);
        store(16'hFF00, 16'h0000);
        store(16'hFF00, 16'hC3C3);
        store(16'hFF00, 16'h7E7E);
        bus_idle();
        check("t3_overflow_set", overflow, 1);
        read_status(st);
        check("t3_status_full_ovf", st, 16'h004B);
        store(16'hFF02, 16'h0000);
        bus_idle();
        check("t3_overflow_clear", overflow, 0);
        read_status(st);
        check("t3_status_after_clear", st, 16'h0043);
        cyc = 0;
        wait_idle(cyc, 1000);
        check("t3_drained", busy, 0);

        // Store to an unmapped address is ignored
        store(16'h0054, 16'hFFFF);
        bus_idle();
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("t4_ignored_bad_cycles", bad, 0);
        read_status(st);
        check("t4_status", st, 16'h0004);

        // Reset mid-frame
        sb.push_back(16'hBEEF);
        store(16'hFF00, 16'hBEEF);
        store(16'hFF00, 16'h1357);
        bus_idle();
        repeat (20) @(negedge clk);
        check("t5_in_frame_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("t5_rst_tx", tx, 1);
        check("t5_rst_busy", busy, 0);
        read_status(st);
        check("t5_rst_status", st, 16'h0004);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        bad = 0;
        repeat (80) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("t5_after_rst_bad_cycles", bad, 0);
        sb.push_back(16'hCAFE);
        store(16'hFF00, 16'hCAFE);
        bus_idle();
        cyc = 0;
        wait_idle(cyc, 200);
        check("t5_clean_frame_cycles", cyc, 73);

        repeat (3) @(negedge clk);
        check("sb_leftover", sb.size(), 0);
        check("frames_done", frames_done, 9);
        check("frames_aborted", frames_aborted, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped serial transmitter on the single-cycle CPU's data-memory write bus (`memwrite`, `dataadr`, `writedata`). Stores to the TX address are queued in a small FIFO and shifted out on a one-wire UART-style line; a status word is readable at a second address. This is the hardware consumer of CPU stores, so programs can emit results off-chip instead of relying on bench probes of data RAM.

## Interface
- `N`, 16: data/address width, matching the CPU word.
- `TX_ADDR`, 16'hFF00: store address that enqueues a word.
- `STATUS_ADDR`, 16'hFF02: status read address; a store here clears `overflow`.
- `CLKS_PER_BIT`, 4: clock cycles per serial bit, must be at least 2.
- `DEPTH`, 4: FIFO entries, a power of 2.
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; `reset`=0 clears all state immediately.
- `memwrite` in 1: CPU store strobe.
- `dataadr` in N: CPU data address.
- `writedata` in N: CPU store data.
- `readdata` out N: status word when `dataadr`==`STATUS_ADDR`, else 0. Combinational.
- `tx` out 1: serial line, idles at 1.
- `busy` out 1: FSM is not in IDLE, or the FIFO is non-empty.
- `overflow` out 1: sticky flag; set when a store is dropped.

## Operation
- Push:
  - Condition: `memwrite` && `dataadr`==`TX_ADDR`.
  - The full `writedata` word enters the FIFO tail.
  - If the FIFO is full and there is no pop in the same cycle, the word is dropped and `overflow` is set.
  - A push and a pop in the same cycle are both performed; count is unchanged and nothing is dropped.
- Clear: `memwrite` && `dataadr`==`STATUS_ADDR` clears `overflow`.
  - If a drop happens in the same cycle as the clear, set wins.
- Frame format: start bit 0, then N data bits LSB first, then stop bit 1. Total N+2 bits.
- FSM states and transitions:
  - IDLE: `tx`=1. If the FIFO is non-empty: pop the head into the shift register, load the baud counter with CLKS_PER_BIT-1, go to START.
  - START: `tx`=0. When the counter reaches 0: reload it, set bit index to 0, go to DATA.
  - DATA: `tx`=shift[0]. When the counter reaches 0: shift right and increment the index; after bit N-1, go to STOP.
  - STOP: `tx`=1. When the counter reaches 0: if the FIFO is non-empty, pop and go straight to START (back-to-back frames); otherwise go to IDLE.
- Status word bits:
  - [0] `busy`
  - [1] full
  - [2] empty
  - [3] `overflow`
  - [3+log2(DEPTH+1):4] FIFO count
  - all other bits 0.
- Stores to any other address are ignored. Read accesses have no side effects.

## Timing
- Reset values: `tx`=1, `busy`=0, `overflow`=0, `readdata`=0 when not addressed, FIFO empty, FSM in IDLE, counters 0.
- Reset asserted mid-frame aborts the frame: `tx` returns to 1 asynchronously and FIFO contents are discarded.
- Latency:
  - Store sampled at edge k: the FIFO holds the word and `busy`=1 after edge k.
  - The pop happens at edge k+1, and `tx` falls after edge k+1.
- Each bit lasts exactly CLKS_PER_BIT cycles. A frame lasts (N+2)·CLKS_PER_BIT cycles; with defaults that is 72.
- Back-to-back frames have no idle gap: the stop bit is followed directly by the next start bit.
- `busy` falls after the last stop-bit cycle, provided the FIFO is empty.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH and is held in log2(DEPTH)+1 bits.

## Structure
- Package `mmio_pkg` holds:
  - the `tx_state_t` enum {IDLE, START, DATA, STOP};
  - the default address constants;
  - the status-bit index constants.
- Sub-module `sync_fifo` (parameters N, DEPTH) provides push, pop, full, empty and count, with simultaneous push and pop supported.
- The top level contains the address decode, the `overflow` flag, the FSM, the baud counter, the bit index and the shift register.

## Test plan
All scenarios use default parameters.
- Reset held low: `tx`=1, `busy`=0, `readdata`=0.
  - Release, then read `STATUS_ADDR` with no stores: `readdata`=16'h0004 (empty only).
- Single store of 16'h0096 to 16'hFF00, one cycle:
  - `tx` falls 1 cycle later.
  - The sampled line is 0, then 0,1,1,0,1,0,0,1, then 0×8, then 1, each bit held 4 cycles.
  - `busy` drops 73 cycles after the store.
- Stores of 16'hA5A5 then 16'h5A5A on consecutive cycles:
  - Two frames, 144 cycles in total, with no gap between stop and start.
  - The status count reads 1 during the first frame.
- Six consecutive stores to an idle block:
  - One word is popped immediately and 4 are queued; the 6th is dropped.
  - `overflow`=1; the status word reads 16'h004B (busy, full, overflow, count 4).
  - A store to 16'hFF02 clears `overflow`.
- Store to 16'h0054 with `memwrite`=1: no FIFO change, `tx` stays 1, `busy` stays 0.
- `reset` pulsed low during DATA of a frame: `tx`=1 immediately, FIFO empty, and the next store produces a clean frame.
